seq_det_arbiter: RTL and testbench

Shares one bit-serial pattern detector among N_REQ serial requesters. Grants are round-robin, and each granted requester streams one frame of `len` bits through the detector. The detector is cleared at every frame start, so no match spans two frames. At frame end the block reports the requester ID and the number of overlapping PATTERN matches. It sits between the serial sources and the shared sequence-detect resource, and is the block that sequences that resource.

---
 rtl/seq_arb_pkg.sv | 14 +
 rtl/seq_det_core.sv | 64 ++++++
 rtl/seq_det_arbiter.sv | 148 ++++++++++++++
 tb/tb_seq_det_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_arb_pkg.sv
// Shared types and default detector constants for the sequence-detect arbiter.
package seq_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      RUN    = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam int                   DEF_PAT_W   = 4;
   localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b0110;

endpackage

// File: rtl/seq_det_core.sv
// Bit-serial overlapping pattern detector with saturating match count and registered z.
module seq_det_core
   import seq_arb_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic             bit_i,
   output logic             z_o,
   output logic [CNT_W-1:0] cnt_d_o
);

   localparam int               FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   logic [PAT_W-2:0]  sr_q;
   logic [FILL_W-1:0] fill_q;
   logic              z_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [PAT_W-1:0]  win;
   logic              hit;

   // Window is the stored history with the incoming bit appended as the newest (LSB).
   assign win = {sr_q, bit_i};
   assign hit = en_i && (fill_q == FILL_MAX) && (win == PATTERN);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!clr || clear_i) begin
         sr_q   <= '0;
         fill_q <= '0;
         z_q    <= 1'b0;
         cnt_q  <= '0;
      end else begin
         z_q   <= hit;
         cnt_q <= cnt_d;
         if (en_i) begin
            sr_q <= win[PAT_W-2:0];
            if (fill_q != FILL_MAX) begin
               fill_q <= fill_q + FILL_W'(1);
            end
         end
      end
   end

   assign z_o     = z_q;
   assign cnt_d_o = cnt_d;

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin sharing of one serial pattern detector among N_REQ requesters.
// Define SEQ_ARB_ABORT_EN to let a requester abort its frame by dropping req.
module seq_det_arbiter
   import seq_arb_pkg::*;
#(
   parameter int               N_REQ   = 4,
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
   parameter int               LEN_W   = 8,
   parameter int               CNT_W   = 8,
   localparam int              ID_W    = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*LEN_W-1:0] len,
   input  logic [N_REQ-1:0]       bit_in,
   output logic [N_REQ-1:0]       gnt,
   output logic                   busy,
   output logic                   z,
   output logic                   done,
   output logic [ID_W-1:0]        done_id,
   output logic [CNT_W-1:0]       match_cnt,
`ifdef SEQ_ARB_ABORT_EN
   output logic                   aborted,
`endif
   output state_t                 dbg_state
);

   state_t           state_q;
   logic [ID_W-1:0]  id_q, ptr_q, pick, pick_j;
   logic [LEN_W-1:0] rem_q, len_sel;
   logic [N_REQ-1:0] gnt_q, pick_oh;
   logic             busy_q, done_q;
   logic [ID_W-1:0]  done_id_q;
   logic [CNT_W-1:0] match_cnt_q, cnt_d;
   logic             abort_now, sample_en, det_clear;

   // Scan from the farthest offset down so the closest set req to ptr_q wins.
   always_comb begin
      pick   = ptr_q;
      pick_j = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pick_j = ID_W'((int'(ptr_q) + k) % N_REQ);
         if (req[pick_j]) pick = pick_j;
      end
   end

   assign pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
   assign len_sel = len[int'(id_q) * LEN_W +: LEN_W];

`ifdef SEQ_ARB_ABORT_EN
   logic aborted_q;
   assign abort_now = (state_q == RUN) && !req[id_q];
   assign aborted   = aborted_q;
`else
   assign abort_now = 1'b0;
`endif

   assign sample_en = (state_q == RUN) && !abort_now;
   assign det_clear = (state_q == GRANT);

   seq_det_core #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN),
      .CNT_W   (CNT_W)
   ) u_core (
      .clk     (clk),
      .clr     (clr),
      .clear_i (det_clear),
      .en_i    (sample_en),
      .bit_i   (bit_in[id_q]),
      .z_o     (z),
      .cnt_d_o (cnt_d)
   );

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q     <= IDLE;
         id_q        <= '0;
         ptr_q       <= '0;
         rem_q       <= '0;
         gnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         done_id_q   <= '0;
         match_cnt_q <= '0;
`ifdef SEQ_ARB_ABORT_EN
         aborted_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|req) begin
                  state_q <= GRANT;
                  id_q    <= pick;
                  gnt_q   <= pick_oh;
                  busy_q  <= 1'b1;
               end
            end
            GRANT: begin
               rem_q <= len_sel;
               ptr_q <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
               if (len_sel == '0) begin
                  state_q     <= REPORT;
                  gnt_q       <= '0;
                  done_q      <= 1'b1;
                  done_id_q   <= id_q;
                  match_cnt_q <= cnt_d;
`ifdef SEQ_ARB_ABORT_EN
                  aborted_q   <= 1'b0;
`endif
               end else begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               rem_q <= rem_q - LEN_W'(1);
               // cnt_d already includes a match on the bit sampled this cycle.
               if (abort_now || (rem_q == LEN_W'(1))) begin
                  state_q     <= REPORT;
                  gnt_q       <= '0;
                  done_q      <= 1'b1;
                  done_id_q   <= id_q;
                  match_cnt_q <= cnt_d;
`ifdef SEQ_ARB_ABORT_EN
                  aborted_q   <= abort_now;
`endif
               end
            end
            REPORT: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign match_cnt = match_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Self-checking bench for seq_det_arbiter: directed frame table, hand sequences, random vs frame-level model.
module tb_seq_det_arbiter;
   import seq_arb_pkg::*;

   localparam int         N   = 4;
   localparam int         PW  = 4;
   localparam logic [3:0] PAT = 4'b0110;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] len_v = '0;
   logic [3:0]  bit_in = '0;
   logic [3:0]  gnt;
   logic        busy, z, done;
   logic [1:0]  done_id;
   logic [7:0]  match_cnt;
   state_t      dbg_state;
`ifdef SEQ_ARB_ABORT_EN
   logic        aborted;
`endif
   logic        last_aborted = 1'b0;

   int checks = 0;
   int errors = 0;

   seq_det_arbiter dut (
      .clk       (clk),
      .clr       (clr),
      .req       (req),
      .len       (len_v),
      .bit_in    (bit_in),
      .gnt       (gnt),
      .busy      (busy),
      .z         (z),
      .done      (done),
      .done_id   (done_id),
      .match_cnt (match_cnt),
`ifdef SEQ_ARB_ABORT_EN
      .aborted   (aborted),
`endif
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Frame-level reference: does the PW-bit window ending at bit k (time order) equal PAT?
   function automatic bit win_match(input logic [15:0] b, input int k);
      logic [PW-1:0] w;
      w = '0;
      for (int j = k - PW + 1; j <= k; j++) w = {w[PW-2:0], b[j]};
      return (w == PAT);
   endfunction

   function automatic int count_matches(input logic [15:0] b, input int n);
      int c;
      c = 0;
      for (int k = PW - 1; k < n; k++) if (win_match(b, k)) c++;
      return c;
   endfunction

   // Runs one frame from an IDLE cycle; returns latency to done and what was reported.
   task automatic run_frame(input int id, input int ln, input logic [15:0] bits, input bit drop5,
                            output int lat, output logic [1:0] rid, output logic [7:0] rcnt,
                            output logic [15:0] zm, output bit gnt_ok);
      req = 4'b0001 << id;
      len_v[id*8 +: 8] = 8'(ln);
      zm = '0; gnt_ok = 1'b1; lat = -1; rid = '0; rcnt = '0;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         step();
         if (z && c >= 3 && c - 3 < 16) zm[c-3] = 1'b1;
         bit_in = 4'($urandom_range(0, 15));
         if (c >= 2 && c - 2 < ln) bit_in[id] = bits[c-2];
         if (!drop5 && c <= ln + 1 && gnt !== (4'b0001 << id)) gnt_ok = 1'b0;
         if (drop5 && c == 6) req = '0;
         if (done) begin
            lat = c; rid = done_id; rcnt = match_cnt;
            if (gnt !== 4'b0000) gnt_ok = 1'b0;
`ifdef SEQ_ARB_ABORT_EN
            last_aborted = aborted;
`endif
            req = '0;
         end
      end
      step();
   endtask

   typedef struct {
      int          id;
      int          len;
      logic [15:0] bits;
      int          exp_cnt;
      logic [15:0] exp_z;
   } vec_t;

   vec_t        vecs[7];
   logic [3:0]  exp_q[$];
   logic [3:0]  got_q[$];

   initial begin
      int          lat, ndone;
      logic [1:0]  rid;
      logic [7:0]  rcnt;
      logic [15:0] zm;
      bit          gok;
      logic [3:0]  prev, e;
      int          m_ptr, m_id, m_len, m_grant, m_done, rep_id, rep_cnt, kk, jj;
      bit          m_active, found;
      logic [15:0] m_bits;
      bit          pend[4];
      logic [15:0] bits_r[4];
      logic [3:0]  exp_gnt;
      bit          exp_busy, exp_done, exp_z;

      vecs[0] = '{0, 7,  16'h0036, 2, 16'h0048};
      vecs[1] = '{1, 3,  16'h0006, 0, 16'h0000};
      vecs[2] = '{1, 1,  16'h0000, 0, 16'h0000};
      vecs[3] = '{3, 0,  16'h0000, 0, 16'h0000};
      vecs[4] = '{2, 8,  16'h0066, 2, 16'h0088};
      vecs[5] = '{0, 4,  16'h0006, 1, 16'h0008};
      vecs[6] = '{2, 10, 16'h01B6, 3, 16'h0248};

      // Reset with every requester asking.
      clr = 1'b0; req = 4'b1111;
      step(); step();
      check("rst_gnt", 32'(gnt), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_cnt", 32'(match_cnt), 0);
      check("rst_z", 32'(z), 0);
      check("rst_id", 32'(done_id), 0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef SEQ_ARB_ABORT_EN
      check("rst_aborted", 32'(aborted), 0);
`endif

      // Round-robin: 0 then 2, then 0 again via pointer wrap.
      req = 4'b0101;
      len_v = {8'd1, 8'd1, 8'd1, 8'd1};
      clr = 1'b1;
      prev = '0;
      for (int c = 0; c < 20; c++) begin
         if (gnt != 4'b0000 && prev == 4'b0000) got_q.push_back(gnt);
         prev = gnt;
         if (done && done_id == 2'd0) req[0] = 1'b0;
         if (done && done_id == 2'd2) req[0] = 1'b1;
         if (got_q.size() == 3) req[2] = 1'b0;
         step();
      end
      exp_q = '{4'b0001, 4'b0100, 4'b0001};
      check("rr_count", 32'(got_q.size()), 3);
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rr_grant", 32'(got_q.pop_front()), 32'(e));
      end

      // Table-driven single frames.
      for (int i = 0; i < 7; i++) begin
         run_frame(vecs[i].id, vecs[i].len, vecs[i].bits, 1'b0, lat, rid, rcnt, zm, gok);
         check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(vecs[i].len + 2));
         check($sformatf("tbl%0d_id", i), 32'(rid), 32'(vecs[i].id));
         check($sformatf("tbl%0d_cnt", i), 32'(rcnt), 32'(vecs[i].exp_cnt));
         check($sformatf("tbl%0d_zmask", i), 32'(zm), 32'(vecs[i].exp_z));
         check($sformatf("tbl%0d_gnt", i), 32'(gok), 1);
      end

      // Abort: drop req in the 5th RUN cycle after bits 0,1,1,0.
      run_frame(1, 10, 16'h0006, 1'b1, lat, rid, rcnt, zm, gok);
`ifdef SEQ_ARB_ABORT_EN
      check("abort_latency", 32'(lat), 7);
      check("abort_flag", 32'(last_aborted), 1);
`else
      check("noabort_latency", 32'(lat), 12);
`endif
      check("abort_id", 32'(rid), 1);
      check("abort_cnt", 32'(rcnt), 1);

      // Reset in mid-frame discards the frame silently.
      req = 4'b0010; len_v[15:8] = 8'd10;
      repeat (4) step();
      clr = 1'b0; req = '0;
      step();
      check("midrst_busy", 32'(busy), 0);
      check("midrst_gnt", 32'(gnt), 0);
      check("midrst_cnt", 32'(match_cnt), 0);
      clr = 1'b1;
      ndone = 0;
      for (int c = 0; c < 15; c++) begin
         if (done) ndone++;
         step();
      end
      check("midrst_nodone", 32'(ndone), 0);

      // Random traffic against a frame-level schedule model.
      clr = 1'b0; req = '0;
      step(); step();
      clr = 1'b1;
      m_ptr = 0; m_id = 0; m_len = 0; m_grant = -10; m_done = -1; m_active = 0;
      m_bits = '0; rep_id = 0; rep_cnt = 0;
      for (int i = 0; i < 4; i++) begin pend[i] = 0; bits_r[i] = '0; end
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int i = 0; i < 4; i++) begin
            if (m_active && cyc == m_done + 1 && i == m_id) begin
               if ($urandom_range(0, 1) == 1) begin
                  pend[i] = 0; req[i] = 1'b0;
               end else begin
                  len_v[i*8 +: 8] = 8'($urandom_range(0, 12)); bits_r[i] = 16'($urandom);
               end
            end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1; req[i] = 1'b1;
               len_v[i*8 +: 8] = 8'($urandom_range(0, 12)); bits_r[i] = 16'($urandom);
            end
         end
         if (cyc > m_done && req != 4'b0000) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
               jj = (m_ptr + k) % 4;
               if (!found && req[jj]) begin found = 1; m_id = jj; end
            end
            m_ptr = (m_id + 1) % 4;
            m_len = int'(len_v[m_id*8 +: 8]);
            m_bits = bits_r[m_id];
            m_grant = cyc + 1;
            m_done = cyc + 2 + m_len;
            m_active = 1;
         end
         bit_in = 4'($urandom_range(0, 15));
         if (m_active && cyc >= m_grant + 1 && cyc <= m_grant + m_len)
            bit_in[m_id] = m_bits[cyc-m_grant-1];
         exp_gnt  = (m_active && cyc >= m_grant && cyc < m_done) ? (4'b0001 << m_id) : 4'b0000;
         exp_busy = m_active && cyc >= m_grant && cyc <= m_done;
         exp_done = m_active && cyc == m_done;
         kk = cyc - m_grant - 2;
         exp_z = m_active && kk >= PW - 1 && kk < m_len && win_match(m_bits, kk);
         if (exp_done) begin
            rep_id = m_id;
            rep_cnt = count_matches(m_bits, m_len);
         end
         check($sformatf("rnd_gnt@%0d", cyc), 32'(gnt), 32'(exp_gnt));
         check($sformatf("rnd_busy@%0d", cyc), 32'(busy), 32'(exp_busy));
         check($sformatf("rnd_done@%0d", cyc), 32'(done), 32'(exp_done));
         check($sformatf("rnd_z@%0d", cyc), 32'(z), 32'(exp_z));
         check($sformatf("rnd_id@%0d", cyc), 32'(done_id), 32'(rep_id));
         check($sformatf("rnd_cnt@%0d", cyc), 32'(match_cnt), 32'(rep_cnt));
`ifdef SEQ_ARB_ABORT_EN
         if (exp_done) check($sformatf("rnd_aborted@%0d", cyc), 32'(aborted), 0);
`endif
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
